uart1_transmitter: RTL and testbench



---
 rtl/uart1_pkg.sv | 29 ++
 rtl/uart1_tx_fifo.sv | 67 ++++++
 rtl/uart1_transmitter.sv | 197 +++++++++++++++++++
 tb/tb_uart1_transmitter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart1_pkg.sv
// uart1_pkg -- definitions shared by the UART1 transmit and receive paths.
//   uart1_state_e      : frame state encoding (IDLE/START/DATA/PARITY/STOP)
//   MCNT_DEFAULT       : default system clock frequency in Hz
//   BAUD_DEFAULT       : default line baud rate
//   uart1_clks_per_bit : system clocks per bit period (integer division)
//   uart1_even_parity  : even parity bit of a data byte
package uart1_pkg;

  typedef enum logic [2:0] {
    UART1_IDLE   = 3'd0,
    UART1_START  = 3'd1,
    UART1_DATA   = 3'd2,
    UART1_PARITY = 3'd3,
    UART1_STOP   = 3'd4
  } uart1_state_e;

  localparam int unsigned MCNT_DEFAULT = 32'd50_000_000;
  localparam int unsigned BAUD_DEFAULT = 32'd9600;

  function automatic int unsigned uart1_clks_per_bit(input int unsigned mcnt,
                                                     input int unsigned baud);
    return mcnt / baud;
  endfunction

  function automatic logic uart1_even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart1_tx_fifo.sv
// uart1_tx_fifo -- synchronous byte FIFO buffering bytes for the transmitter.
// Ports:
//   Clk, Reset_n   : clock, synchronous active-low reset (flushes the FIFO)
//   push/push_data : write a byte (accepted when not full, or full with a pop)
//   pop/pop_data   : read side; pop_data shows the head byte (first-word fall-through)
//   full, empty    : occupancy flags
//   count          : number of stored bytes (0..FIFO_DEPTH)
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
import uart1_pkg::*;

module uart1_tx_fifo #(
  parameter  int unsigned FIFO_DEPTH = 32'd4,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 32'd1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  // A full FIFO may still take a byte when the head leaves in the same cycle.
  assign push_ok_s = push && (!full || pop);
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy count
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart1_transmitter.sv
// uart1_transmitter -- UART transmit engine (8N1, optional even parity).
// Bytes arrive over a valid/ready handshake into a small FIFO and are
// serialised LSB first on Tx at MCNT/Baud clocks per bit.
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : synchronous active-low reset
//   Data_in  : byte to send
//   Send_en  : Data_in valid; accepted on an edge with Send_en && Ready
//   Ready    : FIFO not full (combinational)
//   Tx       : serial line, registered, idle high
//   Tx_busy  : frame in progress or FIFO non-empty
//   Tx_done  : one-cycle pulse on the last cycle of each stop bit
// Build option: define UART1_TX_PARITY_EN to insert an even parity bit
// between data bit 7 and the stop bit (11 bit periods per frame).
import uart1_pkg::*;

module uart1_transmitter #(
  parameter int unsigned MCNT       = MCNT_DEFAULT,
  parameter int unsigned Baud       = BAUD_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 32'd4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Data_in,
  input  logic       Send_en,
  output logic       Ready,
  output logic       Tx,
  output logic       Tx_busy,
  output logic       Tx_done
);

  localparam int unsigned CLKS_PER_BIT = uart1_clks_per_bit(MCNT, Baud);
  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);

  localparam logic [2:0] S_IDLE   = UART1_IDLE;
  localparam logic [2:0] S_START  = UART1_START;
  localparam logic [2:0] S_DATA   = UART1_DATA;
`ifdef UART1_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = UART1_PARITY;
`endif
  localparam logic [2:0] S_STOP   = UART1_STOP;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
`ifdef UART1_TX_PARITY_EN
  logic              parity_r;
`endif
  logic              tx_r;
  logic              tx_done_r;
  logic              line_s;
  logic              done_s;
  logic              bit_end_s;
  logic              push_s;
  logic              pop_s;
  logic [7:0]        fifo_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FCNT_W-1:0] fifo_count_s;

  assign Ready     = !fifo_full_s;
  assign push_s    = Send_en && Ready;
  assign bit_end_s = (bit_cnt_r == CNT_LAST);
  assign Tx        = tx_r;
  assign Tx_done   = tx_done_r;
  assign Tx_busy   = (state_r != S_IDLE) || (fifo_count_s != {FCNT_W{1'b0}});

  uart1_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (push_s),
    .push_data (Data_in),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Next-state and FIFO pop decision; STOP chains straight into START when data waits
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = S_START;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s && (bit_idx_r == 3'd7)) begin
`ifdef UART1_TX_PARITY_EN
          state_nxt_s = S_PARITY;
`else
          state_nxt_s = S_STOP;
`endif
        end else begin
          state_nxt_s = S_DATA;
        end
      end
`ifdef UART1_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = S_STOP;
        end else begin
          state_nxt_s = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s && !fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = S_START;
        end else if (bit_end_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Line level implied by the current state; registered one cycle later onto Tx
  always_comb begin
    line_s = 1'b1;
    done_s = (state_r == S_STOP) && bit_end_s;
    case (state_r)
      S_IDLE:   line_s = 1'b1;
      S_START:  line_s = 1'b0;
      S_DATA:   line_s = shift_r[0];
`ifdef UART1_TX_PARITY_EN
      S_PARITY: line_s = parity_r;
`endif
      S_STOP:   line_s = 1'b1;
      default:  line_s = 1'b1;
    endcase
  end

  // FSM state, bit timing, shift register and registered line outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef UART1_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
      tx_r      <= 1'b1;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tx_r      <= line_s;
      tx_done_r <= done_s;
      if (pop_s) begin
        shift_r   <= fifo_data_s;
`ifdef UART1_TX_PARITY_EN
        // Parity is captured at load since the shift register is consumed.
        parity_r  <= uart1_even_parity(fifo_data_s);
`endif
        bit_cnt_r <= {CNT_W{1'b0}};
        bit_idx_r <= 3'd0;
      end else if (state_r == S_IDLE) begin
        bit_cnt_r <= {CNT_W{1'b0}};
        bit_idx_r <= 3'd0;
      end else if (bit_end_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
        if (state_r == S_DATA) begin
          shift_r   <= {1'b0, shift_r[7:1]};
          bit_idx_r <= bit_idx_r + 3'd1;
        end
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_uart1_transmitter.sv
// tb_uart1_transmitter -- self-checking bench for uart1_transmitter
// (MCNT=8, Baud=1: 8 clocks per bit). Stimulus pushes expected bytes into a
// scoreboard queue; a monitor decodes every frame seen on Tx and compares it
// with an ideal frame built from the queued byte.
module tb_uart1_transmitter;

  localparam int CPB = 8;
`ifdef UART1_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Send_en = 1'b0;
  logic [7:0] Data_in = 8'h00;
  logic       Ready;
  logic       Tx;
  logic       Tx_busy;
  logic       Tx_done;

  uart1_transmitter #(
    .MCNT       (32'd8),
    .Baud       (32'd1),
    .FIFO_DEPTH (32'd4)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Data_in (Data_in),
    .Send_en (Send_en),
    .Ready   (Ready),
    .Tx      (Tx),
    .Tx_busy (Tx_busy),
    .Tx_done (Tx_done)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         done_q[$];

  bit          in_frame = 1'b0;
  bit          orphan   = 1'b0;
  int          samp;
  int          bit_errs;
  int          done_errs;
  logic [10:0] cur_frame;
  logic [10:0] got_bits;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ideal line frame: bit 0 is the start bit, then data LSB first, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
`ifdef UART1_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {2'b11, b, 1'b0};
`endif
    return f;
  endfunction

  // Monitor: detect start bits, check every cycle of the frame and the done pulse
  always @(negedge Clk) begin
    if (Reset_n !== 1'b1) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (Tx_done === 1'b1) check("done_outside_frame", 32'd1, 32'd0);
        if (Tx === 1'b0) begin
          start_q.push_back(cyc);
          samp      = 0;
          bit_errs  = 0;
          done_errs = 0;
          got_bits  = 11'h7FF;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            orphan    = 1'b1;
            cur_frame = 11'h7FE;
          end else begin
            orphan    = 1'b0;
            cur_frame = frame_of(exp_q.pop_front());
          end
          in_frame = 1'b1;
        end
      end
      if (in_frame) begin
        if (Tx !== cur_frame[samp / CPB]) bit_errs++;
        if ((samp % CPB) == (CPB / 2)) got_bits[samp / CPB] = Tx;
        if ((Tx_done === 1'b1) != (samp == FRAME_CYC - 1)) done_errs++;
        if (Tx_done === 1'b1) done_q.push_back(cyc);
        samp++;
        if (samp == FRAME_CYC) begin
          in_frame = 1'b0;
          if (!orphan) begin
            check("frame_bits", 32'(got_bits), 32'(cur_frame));
            check("frame_hold", bit_errs, 32'd0);
            check("frame_done", done_errs, 32'd0);
          end
        end
      end
    end
  end

  // Offer one byte and wait for it to be accepted; returns the accepting edge.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int waited;
    waited  = 0;
    Data_in = b;
    Send_en = 1'b1;
    @(negedge Clk);
    while (Ready !== 1'b1 && waited < 2000) begin
      @(negedge Clk);
      waited++;
    end
    if (Ready !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      Send_en = 1'b0;
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc + 1;
      exp_q.push_back(b);
      @(posedge Clk);
      #1;
      Send_en = 1'b0;
    end
  endtask

  // Wait until every scoreboarded byte has been seen, then expect an idle engine.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 20 * FRAME_CYC) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size() != 0 || in_frame), 32'd0);
    @(negedge Clk);
    check({name, "_busy_low"}, 32'(Tx_busy), 32'd0);
    check({name, "_tx_idle"}, 32'(Tx), 32'd1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc0;
    int n;
    logic [7:0] sb [6];
    int sacc [6];
    int idx;

    // Reset values
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_tx", 32'(Tx), 32'd1);
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_busy", 32'(Tx_busy), 32'd0);
    check("rst_done", 32'(Tx_done), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // Single byte: start latency, frame shape, one done pulse
    start_q.delete();
    done_q.delete();
    send_byte(8'hA5, acc);
    drain("a5");
    check("a5_frames", start_q.size(), 32'd1);
    check("a5_dones", done_q.size(), 32'd1);
    if (start_q.size() == 1 && done_q.size() == 1) begin
      check("a5_latency", start_q[0] - acc, 32'd2);
      check("a5_done_pos", done_q[0] - start_q[0], FRAME_CYC - 1);
    end

    // Back-to-back frames with no idle gap
    start_q.delete();
    done_q.delete();
    send_byte(8'h00, acc);
    send_byte(8'hFF, acc);
    send_byte(8'h3C, acc);
    drain("b2b");
    check("b2b_frames", start_q.size(), 32'd3);
    check("b2b_dones", done_q.size(), 32'd3);
    if (start_q.size() == 3 && done_q.size() == 3) begin
      check("b2b_gap1", start_q[1] - start_q[0], FRAME_CYC);
      check("b2b_gap2", start_q[2] - start_q[1], FRAME_CYC);
      check("b2b_done_gap1", done_q[1] - done_q[0], FRAME_CYC);
      check("b2b_done_gap2", done_q[2] - done_q[1], FRAME_CYC);
    end

    // Send_en held high with 6 bytes: FIFO fills, 6th only after the first frame ends
    for (int i = 0; i < 6; i++) sb[i] = 8'($urandom);
    idx     = 0;
    Data_in = sb[0];
    Send_en = 1'b1;
    for (int c = 0; c < FRAME_CYC + 20; c++) begin
      @(negedge Clk);
      if (c == 10) begin
        check("full_ready_low", 32'(Ready), 32'd0);
        check("full_accepted5", idx, 32'd5);
      end
      if (Ready === 1'b1 && idx < 6) begin
        sacc[idx] = cyc + 1;
        exp_q.push_back(sb[idx]);
        idx++;
      end
      @(posedge Clk);
      #1;
      Send_en = (idx < 6);
      Data_in = (idx < 6) ? sb[idx] : 8'h00;
    end
    Send_en = 1'b0;
    check("full_accepted6", idx, 32'd6);
    if (idx == 6) check("full_refill_time", sacc[5] - sacc[0], FRAME_CYC + 2);
    drain("full");

    // Reset during data bit 3: frame abandoned, FIFO flushed
    start_q.delete();
    done_q.delete();
    send_byte(8'h55, acc);
    send_byte(8'hAA, acc);
    n = 0;
    while (start_q.size() == 0 && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("rst_mid_started", start_q.size(), 32'd1);
    repeat (33) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    exp_q.delete();
    @(negedge Clk);
    check("rst_mid_tx", 32'(Tx), 32'd1);
    check("rst_mid_ready", 32'(Ready), 32'd1);
    check("rst_mid_busy", 32'(Tx_busy), 32'd0);
    check("rst_mid_done", 32'(Tx_done), 32'd0);
    repeat (2 * FRAME_CYC) @(posedge Clk);
    #1;
    check("rst_mid_no_done", done_q.size(), 32'd0);
    check("rst_mid_no_frame", start_q.size(), 32'd1);

    // Parity-sensitive bytes (checked against the frame model either way)
    send_byte(8'h07, acc);
    send_byte(8'h03, acc);
    drain("par");

    // Randomised traffic with random gaps
    start_q.delete();
    acc0 = 0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'($urandom), acc);
      if (i == 0) acc0 = acc;
      repeat ($urandom_range(0, 2 * FRAME_CYC)) @(posedge Clk);
      #1;
    end
    drain("rand");
    check("rand_frames", start_q.size(), 32'd16);
    if (start_q.size() > 0) check("rand_first_latency", start_q[0] - acc0, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
